// File: rtl/matrix_max7219_tx.sv
// matrix_max7219_tx: streams the eight row registers to a MAX7219 8x8 LED matrix driver.
// After reset it sends the 5-word init sequence once, then refreshes rows 1..8 continuously.
// Optional build macro: MATRIX_SNAPSHOT_EN -- captures all rows at the start of each frame (tear-free).
module matrix_max7219_tx #(
  parameter int unsigned DATAWIDTH_BUS = 8,
  parameter int unsigned CLKDIV        = 25,
  parameter logic [3:0]  INTENSITY     = 4'hF
) (
  input  logic                     MT_CLOCK_50,
  input  logic                     MT_RESET,
  input  logic                     MT_ENABLE_IN,
  input  logic [DATAWIDTH_BUS-1:0] MT_REG0_IN,
  input  logic [DATAWIDTH_BUS-1:0] MT_REG1_IN,
  input  logic [DATAWIDTH_BUS-1:0] MT_REG2_IN,
  input  logic [DATAWIDTH_BUS-1:0] MT_REG3_IN,
  input  logic [DATAWIDTH_BUS-1:0] MT_REG4_IN,
  input  logic [DATAWIDTH_BUS-1:0] MT_REG5_IN,
  input  logic [DATAWIDTH_BUS-1:0] MT_REG6_IN,
  input  logic [DATAWIDTH_BUS-1:0] MT_REG7_IN,
  output logic                     MT_DIN_OUT,
  output logic                     MT_SCLK_OUT,
  output logic                     MT_LOAD_OUT,
  output logic                     MT_FRAME_DONE_OUT
);

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned ROW_W      = 8;
  localparam int unsigned ROWS       = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned BIT_W      = 5;
  localparam int unsigned INIT_WORDS = 5;
  localparam int unsigned DIV_W      = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  // Word to send for a given position: init table until init_done, then digit rows.
  function automatic logic [WORD_W-1:0] build_word(
    input logic             idone,
    input logic [IDX_W-1:0] widx,
    input logic [IDX_W-1:0] row,
    input logic [ROW_W-1:0] rdata
  );
    logic [WORD_W-1:0] w;
    w = '0;
    if (!idone) begin
      case (widx)
        3'd0:    w = 16'h0C01;
        3'd1:    w = 16'h0900;
        3'd2:    w = 16'h0B07;
        3'd3:    w = {8'h0A, 4'h0, INTENSITY};
        default: w = 16'h0F00;
      endcase
    end else begin
      w = {4'h0, 4'({1'b0, row} + 4'd1), rdata};
    end
    return w;
  endfunction

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [WORD_W-1:0]  shift_q, shift_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               lat_q, lat_d;
  logic               sclk_q, sclk_d;
  logic               din_q, din_d;
  logic               load_q, load_d;
  logic               fd_q, fd_d;
  logic               init_done_q, init_done_d;
  logic [IDX_W-1:0]   widx_q, widx_d;
  logic [IDX_W-1:0]   row_q, row_d;

  logic               tick_c;
  logic               latch_done_c;
  logic               start_c;
  logic [ROW_W-1:0]   rdata_c;
  logic [WORD_W-1:0]  word_c;
  logic [ROW_W-1:0]   row_in_c [ROWS];

  assign row_in_c[0] = ROW_W'(MT_REG0_IN);
  assign row_in_c[1] = ROW_W'(MT_REG1_IN);
  assign row_in_c[2] = ROW_W'(MT_REG2_IN);
  assign row_in_c[3] = ROW_W'(MT_REG3_IN);
  assign row_in_c[4] = ROW_W'(MT_REG4_IN);
  assign row_in_c[5] = ROW_W'(MT_REG5_IN);
  assign row_in_c[6] = ROW_W'(MT_REG6_IN);
  assign row_in_c[7] = ROW_W'(MT_REG7_IN);

  assign tick_c       = (div_q == DIV_W'(CLKDIV - 1));
  assign latch_done_c = (state_q == ST_LATCH) && tick_c && lat_q;

  // Free-running tick divider.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (tick_c) div_d = '0;
  end

  // Word position: advances when a LATCH completes, whether or not the next word starts.
  always_comb begin
    init_done_d = init_done_q;
    widx_d      = widx_q;
    row_d       = row_q;
    if (latch_done_c) begin
      if (!init_done_q) begin
        if (widx_q == IDX_W'(INIT_WORDS - 1)) begin
          init_done_d = 1'b1;
          row_d       = '0;
        end else begin
          widx_d = widx_q + IDX_W'(1);
        end
      end else begin
        row_d = row_q + IDX_W'(1);
      end
    end
  end

`ifdef MATRIX_SNAPSHOT_EN
  logic [ROW_W-1:0] snap_q [ROWS];
  logic [ROW_W-1:0] snap_d [ROWS];

  // Frame buffer: captured on the start tick of the row-0 word.
  always_comb begin
    snap_d = snap_q;
    if (start_c && init_done_d && (row_d == '0)) begin
      for (int i = 0; i < ROWS; i++) snap_d[i] = row_in_c[i];
    end
  end

  // Row 0 goes straight from the inputs (same values the buffer captures); others from the buffer.
  always_comb begin
    rdata_c = snap_q[row_d];
    if (row_d == '0) rdata_c = row_in_c[0];
  end

  // Frame buffer register.
  always_ff @(posedge MT_CLOCK_50 or negedge MT_RESET) begin
    if (!MT_RESET) begin
      for (int i = 0; i < ROWS; i++) snap_q[i] <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end
`else
  // Each row sampled directly on its own word-start tick.
  always_comb begin
    rdata_c = row_in_c[row_d];
  end
`endif

  assign word_c = build_word(init_done_d, widx_d, row_d, rdata_c);

  // Transmit FSM: next state and serial outputs.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    lat_d   = lat_q;
    sclk_d  = sclk_q;
    din_d   = din_q;
    load_d  = load_q;
    fd_d    = 1'b0;
    start_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tick_c && MT_ENABLE_IN) start_c = 1'b1;
      end
      ST_SHIFT: begin
        if (tick_c) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            bit_d  = bit_q + BIT_W'(1);
          end else if (bit_q == BIT_W'(WORD_W)) begin
            sclk_d  = 1'b0;
            load_d  = 1'b1;
            lat_d   = 1'b0;
            state_d = ST_LATCH;
          end else begin
            sclk_d  = 1'b0;
            shift_d = shift_q << 1;
            din_d   = shift_d[WORD_W-1];
          end
        end
      end
      ST_LATCH: begin
        if (tick_c) begin
          if (!lat_q) begin
            lat_d = 1'b1;
          end else begin
            fd_d = init_done_q && (row_q == IDX_W'(ROWS - 1));
            if (MT_ENABLE_IN) start_c = 1'b1;
            else              state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Word start: shared by IDLE and back-to-back LATCH completion.
    if (start_c) begin
      shift_d = word_c;
      din_d   = word_c[WORD_W-1];
      sclk_d  = 1'b0;
      load_d  = 1'b0;
      bit_d   = '0;
      state_d = ST_SHIFT;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge MT_CLOCK_50 or negedge MT_RESET) begin
    if (!MT_RESET) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      shift_q     <= '0;
      bit_q       <= '0;
      lat_q       <= 1'b0;
      sclk_q      <= 1'b0;
      din_q       <= 1'b0;
      load_q      <= 1'b1;
      fd_q        <= 1'b0;
      init_done_q <= 1'b0;
      widx_q      <= '0;
      row_q       <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      lat_q       <= lat_d;
      sclk_q      <= sclk_d;
      din_q       <= din_d;
      load_q      <= load_d;
      fd_q        <= fd_d;
      init_done_q <= init_done_d;
      widx_q      <= widx_d;
      row_q       <= row_d;
    end
  end

  assign MT_DIN_OUT        = din_q;
  assign MT_SCLK_OUT       = sclk_q;
  assign MT_LOAD_OUT       = load_q;
  assign MT_FRAME_DONE_OUT = fd_q;

endmodule
